// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round engine: round counts,
// FSM encoding and the GF(2^8) / ShiftRows helpers used by the datapath.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_MIX  = 2'd3
  } fsm_t;

  // Multiply by {02} in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // Multiply by {03} = {02} ^ {01}.
  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

  // Row r (byte r of every column word) rotates left by r columns.
  // Byte (col c, row r) sits at bit offset 127 - 8*(4*c + r).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_mixcolumn_word.sv
// Single-column MixColumns. Every output byte is built from the pre-mix
// column bytes only, so the four results are mutually independent.
module aes_mixcolumn_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a, b, c, d;

  assign {a, b, c, d} = col;

  assign mixed = {gm2(a) ^ gm3(b) ^ c      ^ d,
                  a      ^ gm2(b) ^ gm3(c) ^ d,
                  a      ^ b      ^ gm2(c) ^ gm3(d),
                  gm3(a) ^ b      ^ c      ^ gm2(d)};

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encipher datapath. Holds the 128-bit state and sequences
// INIT (AddRoundKey 0), then per round SUB (SubBytes through SBOX_WORDS
// external S-box lanes over 4/SBOX_WORDS cycles) and MIX (ShiftRows,
// MixColumns unless final, AddRoundKey). ready marks a stable result.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int SBOX_WORDS = 1,
  parameter bit AES256_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      next,
  input  logic                      keylen,
  input  logic [127:0]              block,
  output logic [3:0]                round_key_addr,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_WORDS-1:0]  sboxw,
  input  logic [32*SBOX_WORDS-1:0]  new_sboxw,
  output logic [127:0]              new_block,
  output logic                      ready
);

  localparam int         SUB_CYC  = 4 / SBOX_WORDS;
  localparam logic [1:0] SUB_LAST = 2'(SUB_CYC - 1);

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state_reg, state_nxt;
  logic [127:0] block_reg, block_nxt;
  logic [3:0]   nr_reg, nr_nxt;
  logic [3:0]   round_ctr, round_ctr_nxt;
  logic [1:0]   sub_ctr, sub_ctr_nxt;

  logic [31:0]  st_w  [4];
  logic [31:0]  sub_w [4];
  logic [1:0]   widx  [SBOX_WORDS];
  logic [127:0] sub_state;
  logic [127:0] sr_state;
  logic [127:0] mix_state;

  // Lane muxing: lane k serves state word sub_ctr*SBOX_WORDS+k and its
  // S-box result replaces that word; all other words pass through.
  always_comb begin
    sboxw = '0;
    for (int j = 0; j < 4; j++) begin
      st_w[j] = state_reg[127 - 32*j -: 32];
    end
    sub_w = st_w;
    for (int k = 0; k < SBOX_WORDS; k++) begin
      widx[k] = 2'(int'(sub_ctr) * SBOX_WORDS + k);
      sboxw[32*(SBOX_WORDS-1-k) +: 32] = st_w[widx[k]];
      sub_w[widx[k]] = new_sboxw[32*(SBOX_WORDS-1-k) +: 32];
    end
    sub_state = {sub_w[0], sub_w[1], sub_w[2], sub_w[3]};
  end

  assign sr_state = shift_rows(state_reg);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mixcolumn_word u_mix (
      .col   (sr_state[127 - 32*c -: 32]),
      .mixed (mix_state[127 - 32*c -: 32])
    );
  end

  // Next-state and datapath-update logic for the round sequencer.
  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    fsm_nxt        = fsm;
    state_nxt      = state_reg;
    block_nxt      = block_reg;
    nr_nxt         = nr_reg;
    round_ctr_nxt  = round_ctr;
    sub_ctr_nxt    = sub_ctr;
    round_key_addr = 4'd0;
    case (fsm)
      ST_IDLE: begin
        if (next) begin
          block_nxt = block;
          nr_nxt    = (AES256_EN && keylen) ? 4'(NR_AES256) : 4'(NR_AES128);
          fsm_nxt   = ST_INIT;
        end
      end
      ST_INIT: begin
        state_nxt     = block_reg ^ round_key;
        round_ctr_nxt = 4'd1;
        sub_ctr_nxt   = 2'd0;
        fsm_nxt       = ST_SUB;
      end
      ST_SUB: begin
        round_key_addr = round_ctr;
        state_nxt      = sub_state;
        if (sub_ctr == SUB_LAST) begin
          sub_ctr_nxt = 2'd0;
          fsm_nxt     = ST_MIX;
        end else begin
          sub_ctr_nxt = sub_ctr + 2'd1;
        end
      end
      ST_MIX: begin
        round_key_addr = round_ctr;
        if (round_ctr < nr_reg) begin
          state_nxt     = mix_state ^ round_key;
          round_ctr_nxt = round_ctr + 4'd1;
          fsm_nxt       = ST_SUB;
        end else begin
          state_nxt = sr_state ^ round_key;
          fsm_nxt   = ST_IDLE;
        end
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  // Register bank: FSM, counters, state, captured block and round count.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath registers are reset too, so new_block reads zero after reset and an aborted run leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      state_reg <= '0;
      block_reg <= '0;
      nr_reg    <= 4'(NR_AES128);
      round_ctr <= 4'd0;
      sub_ctr   <= 2'd0;
    end else begin
      fsm       <= fsm_nxt;
      state_reg <= state_nxt;
      block_reg <= block_nxt;
      nr_reg    <= nr_nxt;
      round_ctr <= round_ctr_nxt;
      sub_ctr   <= sub_ctr_nxt;
    end
  end

  assign new_block = state_reg;
  assign ready     = (fsm == ST_IDLE);

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine. Four instances cover
// SBOX_WORDS = 1, 2, 4 and AES256_EN = 0. The bench supplies S-box and round
// keys from its own byte-level AES model (S-box derived from the GF(2^8)
// inverse plus affine map, FIPS key expansion, textbook cipher rounds).
module tb_aes_round_engine;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Per-instance signals: 0: W=1, 1: W=2, 2: W=4, 3: W=1 with AES256_EN=0
  logic [3:0]        next_s, keylen_s, ready_s;
  logic [3:0][127:0] block_s, nb_s, rk_s;
  logic [3:0][3:0]   addr_s;
  logic [127:0]      keys [4][16];

  logic [31:0]  sbw0, nsb0, sbw3, nsb3;
  logic [63:0]  sbw1, nsb1;
  logic [127:0] sbw2, nsb2;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_keys [16];
  int           addr_q [$];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 4; g++) begin : g_rk
    assign rk_s[g] = keys[g][addr_s[g]];
  end
  for (genvar b = 0; b < 4; b++) begin : g_sb0
    assign nsb0[8*b +: 8] = sbox_tab[sbw0[8*b +: 8]];
    assign nsb3[8*b +: 8] = sbox_tab[sbw3[8*b +: 8]];
  end
  for (genvar b = 0; b < 8; b++) begin : g_sb1
    assign nsb1[8*b +: 8] = sbox_tab[sbw1[8*b +: 8]];
  end
  for (genvar b = 0; b < 16; b++) begin : g_sb2
    assign nsb2[8*b +: 8] = sbox_tab[sbw2[8*b +: 8]];
  end

  aes_round_engine #(.SBOX_WORDS(1), .AES256_EN(1'b1)) dut_w1 (
    .clk(clk), .reset(reset), .next(next_s[0]), .keylen(keylen_s[0]), .block(block_s[0]),
    .round_key_addr(addr_s[0]), .round_key(rk_s[0]), .sboxw(sbw0), .new_sboxw(nsb0),
    .new_block(nb_s[0]), .ready(ready_s[0]));

  aes_round_engine #(.SBOX_WORDS(2), .AES256_EN(1'b1)) dut_w2 (
    .clk(clk), .reset(reset), .next(next_s[1]), .keylen(keylen_s[1]), .block(block_s[1]),
    .round_key_addr(addr_s[1]), .round_key(rk_s[1]), .sboxw(sbw1), .new_sboxw(nsb1),
    .new_block(nb_s[1]), .ready(ready_s[1]));

  aes_round_engine #(.SBOX_WORDS(4), .AES256_EN(1'b1)) dut_w4 (
    .clk(clk), .reset(reset), .next(next_s[2]), .keylen(keylen_s[2]), .block(block_s[2]),
    .round_key_addr(addr_s[2]), .round_key(rk_s[2]), .sboxw(sbw2), .new_sboxw(nsb2),
    .new_block(nb_s[2]), .ready(ready_s[2]));

  aes_round_engine #(.SBOX_WORDS(1), .AES256_EN(1'b0)) dut_en0 (
    .clk(clk), .reset(reset), .next(next_s[3]), .keylen(keylen_s[3]), .block(block_s[3]),
    .round_key_addr(addr_s[3]), .round_key(rk_s[3]), .sboxw(sbw3), .new_sboxw(nsb3),
    .new_block(nb_s[3]), .ready(ready_s[3]));

  // ---------------- reference model ----------------
  function automatic int sub_cyc_of(input int inst);
    case (inst)
      1:       return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int nr_of(input int inst, input logic kl);
    return (inst != 3 && kl) ? 14 : 10;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = (nr == 14) ? 8 : 4;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      exp_keys[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    end
  endtask

  // Textbook cipher on a byte array; byte i = column i/4, row i%4.
  function automatic logic [127:0] cipher(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] out;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ exp_keys[0][127 - 8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c + r] = gmul(8'h02, t[4*c + r]) ^ gmul(8'h03, t[4*c + (r+1)%4])
                         ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ exp_keys[rnd][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- bench helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_keys(input int inst, input logic [255:0] key, input int nr);
    expand(key, nr);
    for (int r = 0; r < 16; r++) keys[inst][r] = exp_keys[r];
  endtask

  // Starts one operation (caller sits #1 after a rising edge), optionally
  // pulses next at busy cycles pa/pb, and returns at #1 after the edge on
  // which ready rises. lat counts edges from the sampling edge inclusive.
  task automatic run_op(input int inst, input logic kl, input logic [255:0] key,
                        input logic [127:0] pt, input int pa, input int pb,
                        output logic [127:0] ct, output int lat);
    load_keys(inst, key, nr_of(inst, kl));
    addr_q.delete();
    block_s[inst]  = pt;
    keylen_s[inst] = kl;
    next_s[inst]   = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready_s[inst]) break;
      addr_q.push_back(int'(addr_s[inst]));
      next_s[inst]   = (lat == pa || lat == pb);
      block_s[inst]  = {$urandom, $urandom, $urandom, $urandom};
      keylen_s[inst] = ~kl;
    end
    next_s[inst] = 1'b0;
    ct = nb_s[inst];
  endtask

  typedef struct {
    int           inst;
    logic         kl;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
    int           nr;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [7];
    logic [127:0] ct, exp_ct;
    logic [255:0] rkey;
    logic kl;
    int lat, nr, sc, errs, maxa, exp_a;

    build_sbox();
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 16; r++) keys[i][r] = '0;
    reset = 1'b1;
    next_s = '0;
    keylen_s = '0;
    block_s = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_ready[%0d]", i), 128'(ready_s[i]), 128'd1);
      check($sformatf("reset_block[%0d]", i), nb_s[i], 128'h0);
      check($sformatf("reset_addr[%0d]", i), 128'(addr_s[i]), 128'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Known-answer vectors: expected ciphertexts are the FIPS-197 values,
    // latencies are 2 + NR*(4/W + 1).
    vecs[0] = '{0, 1'b0, K128, PT, CT1, 52, 10};
    vecs[1] = '{2, 1'b1, K256, PT, CT3, 30, 14};
    vecs[2] = '{2, 1'b0, K128, PT, CT1, 22, 10};
    vecs[3] = '{0, 1'b1, K256, PT, CT3, 72, 14};
    vecs[4] = '{3, 1'b1, K128, PT, CT1, 52, 10};
    vecs[5] = '{1, 1'b0, K128, PT, CT1, 32, 10};
    vecs[6] = '{1, 1'b1, K256, PT, CT3, 44, 14};
    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].inst, vecs[v].kl, vecs[v].key, vecs[v].pt, -1, -1, ct, lat);
      check($sformatf("kat_ct[%0d]", v), ct, vecs[v].ct);
      check($sformatf("kat_lat[%0d]", v), 128'(lat), 128'(vecs[v].lat));
      sc = sub_cyc_of(vecs[v].inst);
      errs = 0;
      maxa = 0;
      foreach (addr_q[j]) begin
        exp_a = (j == 0) ? 0 : (j - 1) / (sc + 1) + 1;
        if (addr_q[j] != exp_a) errs++;
        if (addr_q[j] > maxa) maxa = addr_q[j];
      end
      check($sformatf("kat_addr_len[%0d]", v), 128'(addr_q.size()), 128'(1 + vecs[v].nr * (sc + 1)));
      check($sformatf("kat_addr_seq_errs[%0d]", v), 128'(errs), 128'd0);
      check($sformatf("kat_addr_max[%0d]", v), 128'(maxa), 128'(vecs[v].nr));
    end

    // next pulses at busy cycles 5 and 20 must not disturb the run.
    run_op(0, 1'b0, K128, PT, 5, 20, ct, lat);
    check("busy_next_ct", ct, CT1);
    check("busy_next_lat", 128'(lat), 128'd52);

    // Reset at cycle 17 of an AES-256 run aborts at once.
    load_keys(0, K256, 14);
    block_s[0]  = PT;
    keylen_s[0] = 1'b1;
    next_s[0]   = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      #1;
      next_s[0] = 1'b0;
    end
    check("midrun_busy", 128'(ready_s[0]), 128'd0);
    reset = 1'b1;
    #1;
    check("abort_ready", 128'(ready_s[0]), 128'd1);
    check("abort_block", nb_s[0], 128'h0);
    check("abort_addr", 128'(addr_s[0]), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_abort_ready", 128'(ready_s[0]), 128'd1);
    run_op(0, 1'b0, K128, PT, -1, -1, ct, lat);
    check("post_abort_ct", ct, CT1);
    check("post_abort_lat", 128'(lat), 128'd52);

    // W=2: 200 random key/plaintext pairs, each started on the cycle ready rises.
    for (int n = 0; n < 200; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl = 1'($urandom_range(0, 1));
      exp_ct = {$urandom, $urandom, $urandom, $urandom};
      run_op(1, kl, rkey, exp_ct, -1, -1, ct, lat);
      nr = nr_of(1, kl);
      exp_ct = cipher(exp_ct, nr);
      check($sformatf("rand_ct[%0d]", n), ct, exp_ct);
      check($sformatf("rand_lat[%0d]", n), 128'(lat), 128'(2 + nr * (sub_cyc_of(1) + 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
